i2c_cfg_sequencer: RTL and testbench
====================================

// Module: i2c_cfg_sequencer
// PURPOSE
//  Walks the 32-bit I2C configuration ROM from entry 0 on a start pulse. Each ROM entry is
//  turned into a register write for the byte-level I2C master, or into a timed wait, until an
//  END entry is reached. Sits between the ROM and the I2C master; brings up the HDMI transmitter.
//  NACKed writes are retried a bounded number of times, then the sequence aborts with an error.
// PARAMETERS
//  LINES       16     ROM depth in entries; address width AW = $clog2(LINES)
//  DW          32     ROM word width; fixed at 32 (checked by elaboration assertion)
//  DELAY_UNIT  1000   clk cycles per DELAY tick
//  MAX_RETRY   3      re-issues of one write after a NACK before error (0 = no retry)
// PORTS
//  clk           in   1    system clock
//  rst           in   1    synchronous, active-high reset
//  start         in   1    1-cycle pulse: run the table from entry 0; ignored while busy
//  busy          out  1    high from the cycle after an accepted start until done/error asserts
//  done          out  1    sticky; set on END or table exhaustion; cleared by the next start
//  error         out  1    sticky; set on retry exhaustion or reserved opcode; cleared by start
//  err_index     out  AW   ROM index of the failing entry; valid while error=1
//  rom_addr      out  AW   ROM address; ROM returns rom_data 1 clk later
//  rom_data      in   32   ROM read data
//  cmd_valid     out  1    write command valid; held until cmd_ready
//  cmd_ready     in   1    master accepts the command on (cmd_valid & cmd_ready)
//  cmd_dev       out  7    7-bit slave address
//  cmd_reg       out  8    register address
//  cmd_data      out  8    register data
//  rsp_valid     in   1    1-cycle pulse: transaction finished
//  rsp_nack      in   1    qualified by rsp_valid; 1 = slave NACKed
// BEHAVIOUR
//  Entry format: [31:24] op, [22:16] dev, [15:8] reg, [7:0] data; bit 23 is ignored.
//   op 0x00 WRITE; 0x01 DELAY, where [23:0] = tick count; 0xFF END; any other op is reserved.
//  Reset: all outputs 0, FSM in IDLE, delay and retry counters cleared.
//   Reset in any state drops cmd_valid at the next edge; a pending master response is discarded.
//  FSM states:
//   IDLE:
//    - start: rom_addr<=0, done<=0, error<=0, busy<=1 -> FETCH.
//   FETCH:
//    - rom_addr is stable this cycle -> WAIT_ROM.
//   WAIT_ROM:
//    - rom_data is valid now; register the entry -> DECODE.
//   DECODE:
//    - WRITE: load cmd_* -> ISSUE.
//    - DELAY: count 0 -> NEXT; otherwise load counter -> WAIT_DLY.
//    - END -> FIN.
//    - reserved op: err_index<=rom_addr -> ERR.
//   ISSUE:
//    - cmd_valid=1; cmd_* stay stable until handshake; handshake -> WAIT_RSP.
//   WAIT_RSP:
//    - rsp_valid & !rsp_nack: clear retry counter -> NEXT.
//    - rsp_valid & rsp_nack & retries<MAX_RETRY: retries++ -> ISSUE (same entry).
//    - otherwise on NACK: err_index<=rom_addr -> ERR.
//    - a rsp_valid in the cycle of the cmd handshake is ignored (master must respond >=1 clk later).
//   WAIT_DLY:
//    - wait ticks*DELAY_UNIT cycles -> NEXT.
//   NEXT:
//    - rom_addr==LINES-1 -> FIN (implicit end, no wrap); otherwise rom_addr++ -> FETCH.
//   FIN:
//    - done<=1, busy<=0 -> IDLE.
//   ERR:
//    - error<=1, busy<=0 -> IDLE.
//  Latency: start -> first cmd_valid = 4 clk (IDLE, FETCH, WAIT_ROM, DECODE).
//   Entry-to-entry overhead after a response is 4 clk.
//  Delay counter is 24+$clog2(DELAY_UNIT) bits wide; it never saturates or wraps.
//  start coincident with rst: rst wins. start while busy: no effect.
// STRUCTURE
//  Shared package i2c_pkg:
//   - i2c_op_e (OP_WRITE=8'h00, OP_DELAY=8'h01, OP_END=8'hFF)
//   - packed struct i2c_entry_t matching the entry format
//   - seq_state_e
//  One sub-module i2c_delay_timer (load, count, expired pulse) holds the WAIT_DLY counting.
//  The ROM and the I2C master are instantiated by the parent, not inside this block.
// TESTING
//  1. ROM {00_39_41_10, 00_39_98_03, FF_000000}, master acks after 5 clk:
//     -> two cmds (39/41/10, 39/98/03), done=1 after the second rsp, error=0.
//  2. ROM {01_000002, FF..}, DELAY_UNIT=4:
//     -> done asserts 8 clk of WAIT_DLY plus overhead after start; cmd_valid stays 0.
//  3. Entry 0 NACKed twice then acked, MAX_RETRY=3:
//     -> 3 identical cmds, done=1. With NACK 4 times: error=1, err_index=0, done=0.
//  4. Hold cmd_ready=0 for 20 clk:
//     -> cmd_valid stays high with stable cmd_*, one handshake only.
//  5. Table full of WRITEs with no END (LINES=16):
//     -> 16 cmds, done after entry 15, rom_addr never wraps to 0.
//  6. rst mid-ISSUE; start during busy; reserved op 0x5A at index 2:
//     -> outputs 0 next clk; extra start ignored; error=1, err_index=2.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types for the I2C configuration sequencer
// Purpose: ROM entry opcodes, packed entry layout and sequencer FSM states.
// Ports: none (package).
package i2c_pkg;

  typedef enum logic [7:0] {
    OP_WRITE = 8'h00,
    OP_DELAY = 8'h01,
    OP_END   = 8'hFF
  } i2c_op_e;

  // [31:24] op, [23] ignored (top bit of a DELAY tick count), [22:16] dev,
  // [15:8] register, [7:0] data.
  typedef struct packed {
    logic [7:0] op;
    logic       rsvd;
    logic [6:0] dev;
    logic [7:0] regaddr;
    logic [7:0] data;
  } i2c_entry_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_ROM,
    S_DECODE,
    S_ISSUE,
    S_WAIT_RSP,
    S_WAIT_DLY,
    S_NEXT,
    S_FIN,
    S_ERR
  } seq_state_e;

endpackage

// File: rtl/i2c_delay_timer.sv
// rtl/i2c_delay_timer.sv - tick-scaled down-counter for DELAY entries
// Purpose: on load, arms ticks*DELAY_UNIT cycles; expired pulses during the
//          last counted cycle so the caller leaves its wait state exactly then.
// Ports: clk, rst (sync, active-high), load, ticks[23:0], count (enable),
//        expired (combinational pulse).
module i2c_delay_timer #(
  parameter int DELAY_UNIT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] ticks,
  input  logic        count,
  output logic        expired
);

  // Wide enough for the largest tick count times the unit, so no saturation.
  localparam int CW = 24 + $clog2(DELAY_UNIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(ticks) * CW'(DELAY_UNIT);
    end else if (count && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = count && (cnt == CW'(1));

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// rtl/i2c_cfg_sequencer.sv - walks the config ROM and drives I2C register writes
// Purpose: on start, reads ROM entries from 0, issues WRITE entries to the byte
//          master (retrying NACKs up to MAX_RETRY), waits on DELAY entries and
//          stops at END, at the last entry, or with an error.
// Ports: clk, rst (sync, active-high), start, busy, done, error, err_index,
//        rom_addr, rom_data, cmd_valid/cmd_ready, cmd_dev, cmd_reg, cmd_data,
//        rsp_valid, rsp_nack.
module i2c_cfg_sequencer
  import i2c_pkg::*;
#(
  parameter int LINES      = 16,
  parameter int DW         = 32,
  parameter int DELAY_UNIT = 1000,
  parameter int MAX_RETRY  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [$clog2(LINES)-1:0] err_index,
  output logic [$clog2(LINES)-1:0] rom_addr,
  input  logic [DW-1:0]            rom_data,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [6:0]               cmd_dev,
  output logic [7:0]               cmd_reg,
  output logic [7:0]               cmd_data,
  input  logic                     rsp_valid,
  input  logic                     rsp_nack
);

  localparam int AW = $clog2(LINES);
  // One spare code keeps the counter at least 1 bit wide when MAX_RETRY is 0.
  localparam int RW = $clog2(MAX_RETRY + 2);

  if (DW != 32) begin : g_dw_check
    $error("i2c_cfg_sequencer: DW must be 32");
  end

  seq_state_e    state;
  i2c_entry_t    entry;
  logic [RW-1:0] retries;
  logic [23:0]   ticks;
  logic          dly_load;
  logic          dly_expired;

  assign ticks    = entry[23:0];
  assign dly_load = (state == S_DECODE) && (entry.op == OP_DELAY) && (ticks != 24'd0);

  i2c_delay_timer #(
    .DELAY_UNIT(DELAY_UNIT)
  ) u_delay (
    .clk    (clk),
    .rst    (rst),
    .load   (dly_load),
    .ticks  (ticks),
    .count  (state == S_WAIT_DLY),
    .expired(dly_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      entry     <= '0;
      retries   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_index <= '0;
      rom_addr  <= '0;
      cmd_valid <= 1'b0;
      cmd_dev   <= '0;
      cmd_reg   <= '0;
      cmd_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rom_addr <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            busy     <= 1'b1;
            retries  <= '0;
            state    <= S_FETCH;
          end
        end
        S_FETCH: state <= S_WAIT_ROM;
        S_WAIT_ROM: begin
          entry <= i2c_entry_t'(rom_data);
          state <= S_DECODE;
        end
        S_DECODE: begin
          case (entry.op)
            OP_WRITE: begin
              cmd_dev   <= entry.dev;
              cmd_reg   <= entry.regaddr;
              cmd_data  <= entry.data;
              cmd_valid <= 1'b1;
              state     <= S_ISSUE;
            end
            OP_DELAY: state <= (ticks == 24'd0) ? S_NEXT : S_WAIT_DLY;
            OP_END:   state <= S_FIN;
            default: begin
              err_index <= rom_addr;
              state     <= S_ERR;
            end
          endcase
        end
        // Responses are not looked at here, so one arriving with the
        // handshake is dropped.
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          if (rsp_valid) begin
            if (!rsp_nack) begin
              retries <= '0;
              state   <= S_NEXT;
            end else if (retries < RW'(MAX_RETRY)) begin
              retries   <= retries + 1'b1;
              cmd_valid <= 1'b1;
              state     <= S_ISSUE;
            end else begin
              err_index <= rom_addr;
              state     <= S_ERR;
            end
          end
        end
        S_WAIT_DLY: begin
          if (dly_expired) state <= S_NEXT;
        end
        S_NEXT: begin
          if (rom_addr == AW'(LINES - 1)) begin
            state <= S_FIN;
          end else begin
            rom_addr <= rom_addr + 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_ERR: begin
          error   <= 1'b1;
          busy    <= 1'b0;
          retries <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// tb/tb_i2c_cfg_sequencer.sv - scoreboard bench for the I2C config sequencer
module tb_i2c_cfg_sequencer;

  localparam int LINES      = 16;
  localparam int DELAY_UNIT = 4;
  localparam int MAX_RETRY  = 3;
  localparam int AW         = 4;
  localparam int BUDGET     = 4000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, error;
  logic [AW-1:0] err_index, rom_addr;
  logic [31:0]   rom_data;
  logic          cmd_valid, cmd_ready;
  logic [6:0]    cmd_dev;
  logic [7:0]    cmd_reg, cmd_data;
  logic          rsp_valid, rsp_nack;

  always #5 clk = ~clk;

  i2c_cfg_sequencer #(
    .LINES(LINES), .DW(32), .DELAY_UNIT(DELAY_UNIT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .err_index(err_index), .rom_addr(rom_addr), .rom_data(rom_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dev(cmd_dev),
    .cmd_reg(cmd_reg), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_nack(rsp_nack)
  );

  logic [31:0] rom [LINES];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int vectors = 0;
  int miscompares = 0;

  logic [22:0]   exp_q[$];
  bit            plan[$];
  bit            nack_q[$];
  int            rsp_lat = 1;
  int            ready_mode = 0;
  int            hold_cycles = 0;
  int            stall_cycles = 0;
  bit            exp_done, exp_error, timed;
  logic [AW-1:0] exp_idx;
  int            exp_cycles;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the table by its entry rules, consuming the NACK plan.
  task automatic run_model();
    int pi, a;
    bit fin, acked;
    logic [31:0] w;
    pi = 0; fin = 0;
    exp_done = 0; exp_error = 0; exp_idx = '0; exp_cycles = 1; timed = 1;
    for (int i = 0; i < LINES && !fin; i++) begin
      w = rom[i];
      exp_cycles += 4;
      case (w[31:24])
        8'h00: begin
          timed = 0; a = 0; acked = 0;
          while (!acked && a <= MAX_RETRY) begin
            exp_q.push_back(w[22:0]);
            acked = !(pi < plan.size() && plan[pi]);
            pi++; a++;
          end
          if (!acked) begin exp_error = 1; exp_idx = AW'(i); fin = 1; end
        end
        8'h01: exp_cycles += int'(w[23:0]) * DELAY_UNIT;
        8'hFF: begin exp_done = 1; fin = 1; end
        default: begin exp_error = 1; exp_idx = AW'(i); fin = 1; end
      endcase
    end
    if (!fin) begin exp_done = 1; exp_cycles += 1; end
  endtask

  // Byte master: responds rsp_lat clocks after each handshake.
  initial begin : master
    rsp_valid = 0; rsp_nack = 0;
    forever begin
      @(negedge clk);
      if (cmd_valid && cmd_ready && !rst) begin
        @(posedge clk);
        repeat (rsp_lat - 1) @(posedge clk);
        #1 rsp_valid = 1;
        rsp_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
        @(posedge clk);
        #1 rsp_valid = 0; rsp_nack = 0;
      end
    end
  end

  // cmd_ready: 0 always-ready, 1 random, 2 hold low hold_cycles, 3 never.
  initial begin : ready_drv
    int stall;
    stall = 0; cmd_ready = 0;
    forever begin
      @(posedge clk); #1;
      stall = cmd_valid ? stall + 1 : 0;
      case (ready_mode)
        0: cmd_ready = 1;
        1: cmd_ready = ($urandom_range(0, 2) != 0);
        2: cmd_ready = (stall > hold_cycles);
        default: cmd_ready = 0;
      endcase
    end
  end

  initial begin : monitor
    logic [22:0] held;
    bit stalled;
    stalled = 0; held = '0;
    forever begin
      @(negedge clk);
      if (cmd_valid) begin
        if (stalled) check("cmd_stable", {cmd_dev, cmd_reg, cmd_data}, held);
        if (cmd_ready) begin
          if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_cmd: got %h expected none", {cmd_dev, cmd_reg, cmd_data});
          end else begin
            check("cmd", {cmd_dev, cmd_reg, cmd_data}, exp_q.pop_front());
          end
          stalled = 0;
        end else begin
          stalled = 1; held = {cmd_dev, cmd_reg, cmd_data}; stall_cycles++;
        end
      end else begin
        stalled = 0;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1);
  end

  task automatic clear_rom();
    for (int i = 0; i < LINES; i++) rom[i] = 32'hFF00_0000;
  endtask

  task automatic run_table(string name, int extra_start);
    int cyc;
    exp_q.delete(); stall_cycles = 0;
    nack_q = plan;
    run_model();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0; cyc = 1;
    check($sformatf("%s_busy", name), busy, 1);
    while (!(done || error) && cyc < BUDGET) begin
      start = (cyc == extra_start);
      @(posedge clk); #1; cyc++;
    end
    start = 0;
    check($sformatf("%s_finished", name), done || error, 1);
    check($sformatf("%s_done", name), done, exp_done);
    check($sformatf("%s_error", name), error, exp_error);
    check($sformatf("%s_busy_end", name), busy, 0);
    if (exp_error) check($sformatf("%s_err_index", name), err_index, exp_idx);
    if (timed) check($sformatf("%s_cycles", name), cyc, exp_cycles);
    check($sformatf("%s_leftover", name), exp_q.size(), 0);
  endtask

  initial begin : stim
    int n, r;
    rst = 1; start = 0;
    clear_rom();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_err_index", err_index, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_fields", {cmd_dev, cmd_reg, cmd_data}, 0);
    rst = 0;

    clear_rom(); plan.delete(); ready_mode = 0; rsp_lat = 5;
    rom[0] = 32'h0039_4110; rom[1] = 32'h0039_9803;
    run_table("basic", 0);

    clear_rom(); rom[0] = 32'h0100_0002;
    run_table("delay", 0);

    clear_rom(); rsp_lat = 2; rom[0] = 32'h0050_1122;
    plan = '{1, 1, 0};
    run_table("nack2", 0);
    plan = '{1, 1, 1, 1};
    run_table("nack4", 0);
    plan.delete();

    clear_rom(); rom[0] = 32'h0021_3344; ready_mode = 2; hold_cycles = 20;
    run_table("stall", 0);
    check("stall_cycles", stall_cycles, 20);
    ready_mode = 0;

    for (int i = 0; i < LINES; i++) rom[i] = {8'h00, 8'(i), 16'($urandom)};
    run_table("full", 0);
    check("full_rom_addr", rom_addr, LINES - 1);

    clear_rom(); rom[0] = 32'h0012_3456; ready_mode = 3;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    n = 0;
    while (!cmd_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("issue_reached", cmd_valid, 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    check("midrst_cmd_valid", cmd_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_fields", {cmd_dev, cmd_reg, cmd_data}, 0);
    check("midrst_rom_addr", rom_addr, 0);
    rst = 0; ready_mode = 0;

    clear_rom(); rom[0] = 32'h0011_0001; rom[1] = 32'h0011_0002;
    run_table("restart", 6);

    clear_rom(); rom[0] = 32'h0033_0102; rom[1] = 32'h0100_0001; rom[2] = 32'h5A00_0000;
    run_table("reserved", 0);

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < LINES; i++) begin
        r = $urandom_range(0, 99);
        if (r < 65)      rom[i] = {8'h00, 24'($urandom)};
        else if (r < 80) rom[i] = {8'h01, 24'($urandom_range(0, 3))};
        else if (r < 93) rom[i] = {8'hFF, 24'($urandom)};
        else             rom[i] = {8'h5A, 24'($urandom)};
      end
      plan.delete();
      for (int k = 0; k < 64; k++) plan.push_back($urandom_range(0, 3) == 0);
      rsp_lat = $urandom_range(1, 4);
      ready_mode = $urandom_range(0, 1);
      run_table($sformatf("rand%0d", t), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
